// File: rtl/nx_msg_encoder_pkg.sv
// NXConstants: shared mesh message types (header, command enum, payload union, instruction).
package NXConstants;

  localparam int unsigned ADDR_ROW_WIDTH = 4;
  localparam int unsigned ADDR_COL_WIDTH = 4;
  localparam int unsigned IO_IDX_WIDTH   = 5;
  localparam int unsigned PAYLOAD_WIDTH  = 21;

  typedef enum logic [1:0] {
    NODE_COMMAND_LOAD_INSTR = 2'd0,
    NODE_COMMAND_OUTPUT_MAP = 2'd1,
    NODE_COMMAND_SIG_STATE  = 2'd2,
    NODE_COMMAND_NODE_CTRL  = 2'd3
  } node_command_t;

  typedef struct packed {
    logic [ADDR_ROW_WIDTH-1:0] row;
    logic [ADDR_COL_WIDTH-1:0] column;
    node_command_t             command;
  } node_header_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] tgt_reg;
    logic [7:0] truth;
    logic       gen_out;
  } instruction_t;

  typedef struct packed {
    instruction_t instr;
    logic [2:0]   padding;
  } node_load_instr_t;

  typedef struct packed {
    logic [IO_IDX_WIDTH-1:0]   source_index;
    logic [ADDR_ROW_WIDTH-1:0] target_row;
    logic [ADDR_COL_WIDTH-1:0] target_column;
    logic [IO_IDX_WIDTH-1:0]   target_index;
    logic                      target_is_seq;
    logic [1:0]                padding;
  } node_map_output_t;

  typedef struct packed {
    logic [IO_IDX_WIDTH-1:0] index;
    logic                    is_seq;
    logic                    state;
    logic [13:0]             padding;
  } node_sig_state_t;

  typedef union packed {
    node_load_instr_t load_instr;
    node_map_output_t output_map;
    node_sig_state_t  sig_state;
  } node_payload_t;

  typedef struct packed {
    node_header_t  header;
    node_payload_t payload;
  } node_message_t;

endpackage

// File: rtl/nx_msg_encoder_fifo.sv
// nx_msg_fifo: small flop-based FIFO; simultaneous push and pop allowed when full.
module nx_msg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/nx_msg_encoder.sv
// nx_msg_encoder: round-robin encoder of map/sig/instr requests into mesh messages.
// Optional macro NX_ENCODER_STATS_EN builds the outbound transfer counter.
module nx_msg_encoder
  import NXConstants::*;
#(
  parameter int unsigned INPUTS     = 32,
  parameter int unsigned OUTPUTS    = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        idle_o,
  input  logic [ADDR_ROW_WIDTH-1:0]   map_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]   map_col_i,
  input  logic [$clog2(OUTPUTS)-1:0]  map_idx_i,
  input  logic [ADDR_ROW_WIDTH-1:0]   map_tgt_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]   map_tgt_col_i,
  input  logic [$clog2(INPUTS)-1:0]   map_tgt_idx_i,
  input  logic                        map_tgt_seq_i,
  input  logic                        map_valid_i,
  output logic                        map_ready_o,
  input  logic [ADDR_ROW_WIDTH-1:0]   sig_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]   sig_col_i,
  input  logic [$clog2(INPUTS)-1:0]   sig_index_i,
  input  logic                        sig_is_seq_i,
  input  logic                        sig_state_i,
  input  logic                        sig_valid_i,
  output logic                        sig_ready_o,
  input  logic [ADDR_ROW_WIDTH-1:0]   instr_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]   instr_col_i,
  input  logic [$bits(instruction_t)-1:0] instr_data_i,
  input  logic                        instr_valid_i,
  output logic                        instr_ready_o,
  output node_message_t               msg_data_o,
  output logic                        msg_valid_o,
  input  logic                        msg_ready_i,
  output logic [31:0]                 sent_count_o
);

  typedef enum logic [1:0] {RR_MAP = 2'd0, RR_SIG = 2'd1, RR_INSTR = 2'd2} rr_t;

  rr_t           rr_q, rr_d;
  logic [2:0]    req_valid, grant;
  logic          fifo_full, fifo_empty, push, pop;
  logic          idle_q;
  node_message_t map_msg, sig_msg, instr_msg, push_data, fifo_data;

  assign req_valid = {instr_valid_i, sig_valid_i, map_valid_i};
  assign pop       = ~fifo_empty & msg_ready_i;

  // Round-robin grant starting at rr_q; only when a slot is free this cycle
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    case (rr_q)
      RR_MAP: begin
        if (req_valid[0])      grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
      end
      RR_SIG: begin
        if (req_valid[1])      grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
      end
      RR_INSTR: begin
        if (req_valid[2])      grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
      end
      default: grant = '0;
    endcase
    if (rst_i || (fifo_full && !pop)) grant = '0;
    if (grant[0])      rr_d = RR_SIG;
    else if (grant[1]) rr_d = RR_INSTR;
    else if (grant[2]) rr_d = RR_MAP;
  end

  assign map_ready_o   = grant[0];
  assign sig_ready_o   = grant[1];
  assign instr_ready_o = grant[2];
  assign push          = |grant;

  always_comb begin
    map_msg   = '0;
    sig_msg   = '0;
    instr_msg = '0;
    map_msg.header.row                      = map_row_i;
    map_msg.header.column                   = map_col_i;
    map_msg.header.command                  = NODE_COMMAND_OUTPUT_MAP;
    map_msg.payload.output_map.source_index  = IO_IDX_WIDTH'(map_idx_i);
    map_msg.payload.output_map.target_row    = map_tgt_row_i;
    map_msg.payload.output_map.target_column = map_tgt_col_i;
    map_msg.payload.output_map.target_index  = IO_IDX_WIDTH'(map_tgt_idx_i);
    map_msg.payload.output_map.target_is_seq = map_tgt_seq_i;
    sig_msg.header.row                      = sig_row_i;
    sig_msg.header.column                   = sig_col_i;
    sig_msg.header.command                  = NODE_COMMAND_SIG_STATE;
    sig_msg.payload.sig_state.index         = IO_IDX_WIDTH'(sig_index_i);
    sig_msg.payload.sig_state.is_seq        = sig_is_seq_i;
    sig_msg.payload.sig_state.state         = sig_state_i;
    instr_msg.header.row                    = instr_row_i;
    instr_msg.header.column                 = instr_col_i;
    instr_msg.header.command                = NODE_COMMAND_LOAD_INSTR;
    instr_msg.payload.load_instr.instr      = instruction_t'(instr_data_i);
  end

  always_comb begin
    push_data = instr_msg;
    if (grant[0])      push_data = map_msg;
    else if (grant[1]) push_data = sig_msg;
  end

  nx_msg_fifo #(
    .WIDTH ($bits(node_message_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign msg_valid_o = ~fifo_empty;
  assign msg_data_o  = fifo_empty ? '0 : fifo_data;
  assign idle_o      = idle_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= RR_MAP;
      idle_q <= 1'b1;
    end else begin
      rr_q   <= rr_d;
      idle_q <= fifo_empty & ~|req_valid;
    end
  end

`ifdef NX_ENCODER_STATS_EN
  logic [31:0] sent_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    sent_cnt_q <= '0;
    else if (pop) sent_cnt_q <= sent_cnt_q + 32'(1);
  end

  assign sent_count_o = sent_cnt_q;
`else
  assign sent_count_o = '0;
`endif

endmodule

// File: tb/tb_nx_msg_encoder.sv
// Bench for nx_msg_encoder: directed scenarios plus random traffic against a queue-based model.
module tb_nx_msg_encoder;
  import NXConstants::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned IW    = $bits(instruction_t);
  localparam int unsigned MW    = $bits(node_message_t);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          idle_o;
  logic [3:0]    map_row_i, map_col_i, map_tgt_row_i, map_tgt_col_i;
  logic [4:0]    map_idx_i, map_tgt_idx_i;
  logic          map_tgt_seq_i, map_valid_i, map_ready_o;
  logic [3:0]    sig_row_i, sig_col_i;
  logic [4:0]    sig_index_i;
  logic          sig_is_seq_i, sig_state_i, sig_valid_i, sig_ready_o;
  logic [3:0]    instr_row_i, instr_col_i;
  logic [IW-1:0] instr_data_i;
  logic          instr_valid_i, instr_ready_o;
  logic [MW-1:0] msg_data_o;
  logic          msg_valid_o, msg_ready_i;
  logic [31:0]   sent_count_o;

  always #5 clk_i = ~clk_i;

  nx_msg_encoder #(.INPUTS(32), .OUTPUTS(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .idle_o(idle_o),
    .map_row_i(map_row_i), .map_col_i(map_col_i), .map_idx_i(map_idx_i),
    .map_tgt_row_i(map_tgt_row_i), .map_tgt_col_i(map_tgt_col_i),
    .map_tgt_idx_i(map_tgt_idx_i), .map_tgt_seq_i(map_tgt_seq_i),
    .map_valid_i(map_valid_i), .map_ready_o(map_ready_o),
    .sig_row_i(sig_row_i), .sig_col_i(sig_col_i), .sig_index_i(sig_index_i),
    .sig_is_seq_i(sig_is_seq_i), .sig_state_i(sig_state_i),
    .sig_valid_i(sig_valid_i), .sig_ready_o(sig_ready_o),
    .instr_row_i(instr_row_i), .instr_col_i(instr_col_i), .instr_data_i(instr_data_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .msg_data_o(msg_data_o), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
    .sent_count_o(sent_count_o)
  );

  // Pending requests per channel (0 map, 1 sig, 2 instr) and their expected encodings
  logic          req_v [3];
  logic [3:0]    r_row [3], r_col [3];
  logic [4:0]    m_idx, m_tidx, s_idx;
  logic [3:0]    m_trow, m_tcol;
  logic          m_seq, s_seq, s_state;
  logic [IW-1:0] i_data;
  logic [MW-1:0] exp_msg [3];

  // Reference model state
  logic [MW-1:0] q [$];
  int            rr;
  logic          idle_m;
  logic [31:0]   sent_m;
  int            p_new [3];
  int            rdy_pct;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int c);
    r_row[c] = 4'($urandom);
    r_col[c] = 4'($urandom);
    req_v[c] = 1'b1;
    case (c)
      0: begin
        m_idx = 5'($urandom); m_trow = 4'($urandom); m_tcol = 4'($urandom);
        m_tidx = 5'($urandom); m_seq = 1'($urandom);
        exp_msg[0] = {r_row[0], r_col[0], 2'd1, m_idx, m_trow, m_tcol, m_tidx, m_seq, 2'b00};
      end
      1: begin
        s_idx = 5'($urandom); s_seq = 1'($urandom); s_state = 1'($urandom);
        exp_msg[1] = {r_row[1], r_col[1], 2'd2, s_idx, s_seq, s_state, 14'd0};
      end
      default: begin
        i_data = IW'($urandom);
        exp_msg[2] = {r_row[2], r_col[2], 2'd0, i_data, 3'd0};
      end
    endcase
  endtask

  task automatic set_sig(input logic [3:0] row, input logic [3:0] col, input logic [4:0] idx,
                         input logic st);
    r_row[1] = row; r_col[1] = col; s_idx = idx; s_seq = 1'b0; s_state = st; req_v[1] = 1'b1;
    exp_msg[1] = {row, col, 2'd2, idx, 1'b0, st, 14'd0};
  endtask

  task automatic drive();
    map_valid_i = req_v[0]; map_row_i = r_row[0]; map_col_i = r_col[0];
    map_idx_i = m_idx; map_tgt_row_i = m_trow; map_tgt_col_i = m_tcol;
    map_tgt_idx_i = m_tidx; map_tgt_seq_i = m_seq;
    sig_valid_i = req_v[1]; sig_row_i = r_row[1]; sig_col_i = r_col[1];
    sig_index_i = s_idx; sig_is_seq_i = s_seq; sig_state_i = s_state;
    instr_valid_i = req_v[2]; instr_row_i = r_row[2]; instr_col_i = r_col[2];
    instr_data_i = i_data;
  endtask

  function automatic logic [31:0] exp_count();
`ifdef NX_ENCODER_STATS_EN
    return sent_m;
`else
    return 32'd0;
`endif
  endfunction

  // One cycle: drive, compare against the model, then advance the model across the edge
  task automatic step();
    bit pop, can;
    int g, sz;
    bit any_v;
    @(negedge clk_i);
    for (int c = 0; c < 3; c++)
      if (!req_v[c] && $urandom_range(99) < p_new[c]) new_req(c);
    drive();
    msg_ready_i = ($urandom_range(99) < rdy_pct);
    #1;
    sz  = q.size();
    pop = (sz > 0) && msg_ready_i;
    can = (sz < DEPTH) || pop;
    g   = -1;
    if (can)
      for (int k = 0; k < 3; k++)
        if (g < 0 && req_v[(rr + k) % 3]) g = (rr + k) % 3;
    check_eq("msg_valid", 64'(msg_valid_o), 64'(sz > 0));
    if (sz > 0) check_eq("msg_data", 64'(msg_data_o), 64'(q[0]));
    check_eq("map_ready", 64'(map_ready_o), 64'(g == 0));
    check_eq("sig_ready", 64'(sig_ready_o), 64'(g == 1));
    check_eq("instr_ready", 64'(instr_ready_o), 64'(g == 2));
    check_eq("idle", 64'(idle_o), 64'(idle_m));
    check_eq("sent_count", 64'(sent_count_o), 64'(exp_count()));
    any_v = req_v[0] | req_v[1] | req_v[2];
    if (pop) begin
      void'(q.pop_front());
      sent_m = sent_m + 32'd1;
    end
    if (g >= 0) begin
      q.push_back(exp_msg[g]);
      req_v[g] = 1'b0;
      rr = (g + 1) % 3;
    end
    idle_m = (sz == 0) && !any_v;
  endtask

  task automatic model_reset();
    q.delete();
    rr = 0; idle_m = 1'b1; sent_m = 32'd0;
    for (int c = 0; c < 3; c++) req_v[c] = 1'b0;
  endtask

  task automatic check_in_reset(input string tag);
    map_valid_i = 1'b1; sig_valid_i = 1'b1; instr_valid_i = 1'b1; msg_ready_i = 1'b1;
    #1;
    check_eq({tag, "_valid"}, 64'(msg_valid_o), 64'd0);
    check_eq({tag, "_readies"}, 64'({map_ready_o, sig_ready_o, instr_ready_o}), 64'd0);
    check_eq({tag, "_idle"}, 64'(idle_o), 64'd1);
    check_eq({tag, "_data"}, 64'(msg_data_o), 64'd0);
    check_eq({tag, "_count"}, 64'(sent_count_o), 64'd0);
  endtask

  initial begin
    int issued;
    rst_i = 1'b1;
    msg_ready_i = 1'b0;
    m_idx = '0; m_trow = '0; m_tcol = '0; m_tidx = '0; m_seq = 1'b0;
    s_idx = '0; s_seq = 1'b0; s_state = 1'b0; i_data = '0;
    for (int c = 0; c < 3; c++) begin
      req_v[c] = 1'b0; r_row[c] = '0; r_col[c] = '0; exp_msg[c] = '0; p_new[c] = 0;
    end
    model_reset();
    drive();
    repeat (2) @(negedge clk_i);
    check_in_reset("reset");
    @(negedge clk_i);
    model_reset();
    drive();
    rst_i = 1'b0;
    rdy_pct = 100;

    // Single sig request, then idle returns
    set_sig(4'd2, 4'd3, 5'd5, 1'b1);
    repeat (4) step();

    // Move pointer back to map, then all three at once
    new_req(2);
    repeat (3) step();
    new_req(0); new_req(1); new_req(2);
    repeat (6) step();

    // Backpressure: four sig requests against a two-entry buffer, then a pending instr
    rdy_pct = 0;
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      if (!req_v[1] && issued < 4) begin new_req(1); issued++; end
      step();
    end
    new_req(2);
    step();
    rdy_pct = 100;
    for (int i = 0; i < 10; i++) begin
      if (!req_v[1] && issued < 4) begin new_req(1); issued++; end
      step();
    end

    // Reset mid-operation with two buffered messages
    rdy_pct = 0;
    new_req(0); new_req(2);
    repeat (4) step();
    @(negedge clk_i);
    rst_i = 1'b1;
    check_in_reset("midreset");
    @(negedge clk_i);
    model_reset();
    drive();
    rst_i = 1'b0;
    rdy_pct = 100;
    repeat (4) step();

`ifdef NX_ENCODER_STATS_EN
    // Counter wrap from all-ones
    @(negedge clk_i);
    force dut.sent_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.sent_cnt_q;
    sent_m = 32'hFFFF_FFFF;
    new_req(1);
    repeat (4) step();
`endif

    // Random traffic
    for (int c = 0; c < 3; c++) p_new[c] = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) rdy_pct = $urandom_range(100);
      step();
    end
    for (int c = 0; c < 3; c++) p_new[c] = 0;
    rdy_pct = 100;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
